// File: rtl/spi_pkg.sv
// spi_pkg: state encoding and shared defaults for the SPI slave control FSM.
package spi_pkg;

    localparam int unsigned SPI_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_ADDR   = 3'd1,
        ST_GOT_ADDR   = 3'd2,
        ST_READ_LOAD  = 3'd3,
        ST_READ_SHIFT = 3'd4,
        ST_WRITE_GET  = 3'd5,
        ST_WRITE_MEM  = 3'd6,
        ST_DONE       = 3'd7
    } spi_state_t;

    // States that consume sclk edges through the bit counter.
    function automatic logic is_shift_state(input spi_state_t s);
        return (s == ST_GET_ADDR) || (s == ST_WRITE_GET) || (s == ST_READ_SHIFT);
    endfunction

endpackage

// File: rtl/spi_bitcounter.sv
// spi_bitcounter: saturating count of sclk edges within one SPI frame.
module spi_bitcounter
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             incr,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    // Holds at DATA_WIDTH so a late edge can never wrap the frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (incr && !done) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;
    assign done  = (r_count == CNT_W'(DATA_WIDTH));

endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: Moore control FSM for an SPI slave (address frame, then read or write frame).
// Optional frame-stall abort is enabled by defining SPI_FSM_TIMEOUT_EN.
module spi_fsm
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = SPI_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic cs_n,
    input  logic sclk_edge,
    input  logic sr_lsb,
    output logic addr_we,
    output logic sr_load,
    output logic dm_we,
    output logic miso_en,
    output logic busy,
    output logic timeout
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

    spi_state_t       r_state;
    spi_state_t       r_next;
    logic             w_clear;
    logic             w_incr;
    logic [CNT_W-1:0] w_count;
    logic             w_done;
    logic             w_to_fire;

    spi_bitcounter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bitcounter (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .incr  (w_incr),
        .count (w_count),
        .done  (w_done)
    );

`ifdef SPI_FSM_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    assign w_to_fire = is_shift_state(r_state) && !sclk_edge && !w_done
                       && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Stall counter restarts on every edge and on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_fire && !cs_n;
            if (!is_shift_state(r_state) || sclk_edge || (r_next != r_state)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_to_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Chip-select release wins over everything, including a coincident edge.
    always_comb begin
        r_next  = r_state;
        w_clear = 1'b0;
        w_incr  = 1'b0;
        if (cs_n) begin
            r_next = ST_IDLE;
        end else if (w_to_fire) begin
            r_next = ST_DONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_next  = ST_GET_ADDR;
                    w_clear = 1'b1;
                end
                ST_GET_ADDR: begin
                    if (w_done) r_next = ST_GOT_ADDR;
                    else        w_incr = sclk_edge;
                end
                ST_GOT_ADDR: begin
                    w_clear = 1'b1;
                    r_next  = sr_lsb ? ST_READ_LOAD : ST_WRITE_GET;
                end
                ST_READ_LOAD: r_next = ST_READ_SHIFT;
                ST_READ_SHIFT: begin
                    if (w_done) r_next = ST_DONE;
                    else        w_incr = sclk_edge;
                end
                ST_WRITE_GET: begin
                    if (w_done) r_next = ST_WRITE_MEM;
                    else        w_incr = sclk_edge;
                end
                ST_WRITE_MEM: r_next = ST_DONE;
                ST_DONE:      r_next = ST_DONE;
                default:      r_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        addr_we = 1'b0;
        sr_load = 1'b0;
        dm_we   = 1'b0;
        miso_en = 1'b0;
        busy    = (r_state != ST_IDLE);
        case (r_state)
            ST_GOT_ADDR:   addr_we = 1'b1;
            ST_READ_LOAD:  sr_load = 1'b1;
            ST_READ_SHIFT: miso_en = 1'b1;
            ST_WRITE_MEM:  dm_we   = 1'b1;
            default:       ;
        endcase
    end

endmodule

// File: doc/spi_fsm.md
SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI frame (address frame and data frame).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the clk cycles without an sclk edge before abort (used only under SPI_FSM_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cs_n  input  1  conditioned chip select, active low.
REQ-006 SHALL have port sclk_edge  input  1  one-cycle pulse per conditioned SCLK rising edge.
REQ-007 SHALL have port sr_lsb  input  1  shift-register bit 0, which is the R/W flag after the address frame (1 = read).
REQ-008 SHALL have port addr_we  output  1  one-cycle address-latch write enable.
REQ-009 SHALL have port sr_load  output  1  one-cycle shift-register parallel-load strobe.
REQ-010 SHALL have port dm_we  output  1  one-cycle data-memory write enable.
REQ-011 SHALL have port miso_en  output  1  MISO tri-state buffer enable.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port timeout  output  1  one-cycle abort pulse.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_MEM and DONE; every output is decoded from the registered state only (no input-to-output path).
REQ-015 SHALL move IDLE→GET_ADDR on the first cycle cs_n=0, clearing the bit counter.
REQ-016 SHALL, in GET_ADDR, WRITE_GET and READ_SHIFT, increment the bit counter on each sclk_edge and leave the state on the cycle after the DATA_WIDTH-th edge; the counter is $clog2(DATA_WIDTH)+1 bits wide and never wraps.
REQ-017 SHALL move GET_ADDR→GOT_ADDR after the counter reaches DATA_WIDTH.
REQ-018 SHALL assert addr_we for exactly one cycle in GOT_ADDR and sample sr_lsb in that cycle: 1 goes to READ_LOAD, 0 goes to WRITE_GET, and the bit counter is cleared.
REQ-019 SHALL assert sr_load for exactly one cycle in READ_LOAD, then enter READ_SHIFT.
REQ-020 SHALL assert miso_en throughout READ_SHIFT and go to DONE after DATA_WIDTH edges.
REQ-021 SHALL go WRITE_GET→WRITE_MEM after DATA_WIDTH edges, assert dm_we for exactly one cycle in WRITE_MEM, then enter DONE.
REQ-022 SHALL hold DONE, with all strobes and miso_en low, until cs_n=1.
REQ-023 SHALL return to IDLE on the next clk edge whenever cs_n=1, from any state; cs_n=1 takes priority over a simultaneous sclk_edge, and no strobe is issued on that edge.
REQ-024 SHALL ignore sclk_edge in IDLE, GOT_ADDR, READ_LOAD, WRITE_MEM and DONE.

Reset
REQ-025 SHALL, on reset=1, immediately set state=IDLE, bit counter=0 and timeout counter=0, and drive addr_we, sr_load, dm_we, miso_en, busy and timeout to 0, regardless of clk.
REQ-026 SHALL, after reset is released mid-transaction with cs_n still 0, enter GET_ADDR on the next clk edge.

Configuration
REQ-027 SHALL, when SPI_FSM_TIMEOUT_EN is defined, count clk cycles without sclk_edge while in GET_ADDR, WRITE_GET or READ_SHIFT; any sclk_edge or state change clears the count; on reaching TIMEOUT_CYCLES the FSM enters DONE and pulses timeout for one cycle.
REQ-028 SHALL, when SPI_FSM_TIMEOUT_EN is undefined, omit the timeout counter and tie the timeout port to 0.

Structure
REQ-029 SHALL take the state enumeration and the DATA_WIDTH default from the shared package spi_pkg.
REQ-030 SHALL instantiate one sub-module, spi_bitcounter, with inputs clear and incr and outputs count and done (done = count == DATA_WIDTH).

Verification
REQ-031 SHALL cover a write: cs_n=0, 8 edges with frame 0x54 (R/W=0), 8 edges with data -> addr_we one cycle after the 8th address edge, dm_we exactly once after the 16th edge, miso_en never high.
REQ-032 SHALL cover a read: frame 0x55 (R/W=1) -> addr_we, sr_load on the next cycle, miso_en high for exactly 8 edges, then DONE.
REQ-033 SHALL cover an abort: cs_n rises after the 5th address edge -> IDLE the next cycle, no addr_we/dm_we, and a following transaction works normally.
REQ-034 SHALL cover a collision: cs_n=1 in the same cycle as the 8th data edge of a write -> dm_we never asserted.
REQ-035 SHALL cover reset: reset asserted mid-READ_SHIFT between clk edges -> miso_en and busy go 0 immediately.
REQ-036 SHALL cover timeout: with SPI_FSM_TIMEOUT_EN and TIMEOUT_CYCLES=16, no sclk for 16 cycles in WRITE_GET -> one-cycle timeout pulse, state DONE, dm_we never asserted.
